div_prog: RTL and testbench

Parametrised programmable integer clock divider, the successor to the fixed dual-modulus divide-by-2/3 cell. It divides `clk_in` by any ratio from 2 to 2^W−1. The ratio is changed glitch-free, only at output-period boundaries. A per-period modulus pulse lets it drive or chain with the prescaler stages in the divider hierarchy.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_duty50.sv | 28 ++
 rtl/div_prog.sv | 97 +++++++++
 tb/tb_div_prog.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the programmable clock divider family.
package div_pkg;

   localparam int DIV_DEFAULT_W   = 4;
   localparam int DIV_MIN_RATIO   = 2;
   localparam int DIV_RESET_RATIO = 2;

   // Ratio word at the default width; parameterised instances declare their own.
   typedef logic [DIV_DEFAULT_W-1:0] div_ratio_t;

endpackage

// File: rtl/div_duty50.sv
// Negative-edge half-cycle extension cell: stretches the posedge high term by
// half an input period so odd ratios reach a 50% duty cycle.
module div_duty50 (
   input  logic clk_in,
   input  logic rst_n,
   input  logic en,
   input  logic hi_in,
   output logic ext_out
);

   logic ext_q;
   logic ext_d;

   always_comb begin
      ext_d = en ? hi_in : ext_q;
   end

   always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ext_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
      end
   end

   assign ext_out = ext_q;

endmodule

// File: rtl/div_prog.sv
// Programmable integer clock divider (ratios 2..2^W-1) with per-period modulus
// pulse. Define DIV_DUTY50_EN to add the negedge cell that gives odd ratios 50% duty.
module div_prog
   import div_pkg::*;
#(
   parameter int unsigned W = DIV_DEFAULT_W
) (
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] ratio,
   output logic         clk_out,
   output logic         mod_out,
   output logic         ratio_err
);

   typedef logic [W-1:0] ratio_t;

   localparam ratio_t RESET_RATIO = ratio_t'(DIV_RESET_RATIO);
   localparam ratio_t MIN_RATIO   = ratio_t'(DIV_MIN_RATIO);
   localparam ratio_t ONE         = ratio_t'(1);

   ratio_t cnt_q, cnt_d;
   ratio_t act_q, act_d;
   logic   run_q, run_d;
   logic   clk_q, clk_d;
   logic   mod_q, mod_d;
   logic   err_q, err_d;

   always_comb begin
      // NOTE: every output of this block gets a hold default first, so no path leaves one unassigned and no latch is inferred.
      cnt_d = cnt_q;
      act_d = act_q;
      run_d = run_q;
      clk_d = clk_q;
      mod_d = mod_q;
      err_d = err_q;
      if (en) begin
         run_d = 1'b1;
         if (!run_q || (cnt_q == act_q - ONE)) begin
            // Period start: the only point where the requested ratio is sampled.
            cnt_d = '0;
            if (ratio >= MIN_RATIO) begin
               act_d = ratio;
               err_d = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
         // Outputs are registered from the next position so they line up with cnt.
         clk_d = (cnt_d < (act_d >> 1));
         mod_d = (cnt_d == act_d - ONE);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
         act_q <= RESET_RATIO;
         run_q <= 1'b0;
         clk_q <= 1'b0;
         mod_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         act_q <= act_d;
         run_q <= run_d;
         clk_q <= clk_d;
         mod_q <= mod_d;
         err_q <= err_d;
      end
   end

`ifdef DIV_DUTY50_EN
   logic ext;

   // Only odd ratios need the extra half cycle; even ratios are already 50%.
   div_duty50 u_duty50 (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en),
      .hi_in   (clk_q & act_q[0]),
      .ext_out (ext)
   );

   assign clk_out = clk_q | ext;
`else
   assign clk_out = clk_q;
`endif

   assign mod_out   = mod_q;
   assign ratio_err = err_q;

endmodule

// File: tb/tb_div_prog.sv
// Self-checking bench for div_prog: directed scenarios plus randomized traffic
// against a period/position reference model and measured clk_out edge times.
module tb_div_prog;
   import div_pkg::*;

   localparam int  W    = $bits(div_ratio_t);
   localparam time TCLK = 10;
`ifdef DIV_DUTY50_EN
   localparam bit  DUTY = 1'b1;
`else
   localparam bit  DUTY = 1'b0;
`endif
   localparam time R3_HIGH = DUTY ? 15 : 10;
   localparam time R5_HIGH = DUTY ? 25 : 20;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       en;
   div_ratio_t ratio;
   logic       clk_out;
   logic       mod_out;
   logic       ratio_err;

   int n_checks;
   int n_fail;

   div_prog #(.W(W)) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en),
      .ratio     (ratio),
      .clk_out   (clk_out),
      .mod_out   (mod_out),
      .ratio_err (ratio_err)
   );

   always #(TCLK/2) clk_in = ~clk_in;

   // Edge-time monitor on the divided clock.
   time t_rise, last_period, last_high;
   always @(posedge clk_out) begin
      last_period = $time - t_rise;
      t_rise      = $time;
   end
   always @(negedge clk_out) last_high = $time - t_rise;

   // Reference model: position within a period of length m_r.
   bit m_run, m_err;
   int m_pos, m_r;

   task automatic model_edge();
      if (!rst_n) begin
         m_run = 1'b0; m_pos = 0; m_r = 2; m_err = 1'b0;
      end else if (en) begin
         if (!m_run || m_pos == m_r - 1) begin
            m_run = 1'b1;
            m_pos = 0;
            if (int'(ratio) >= 2) begin
               m_r = int'(ratio); m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end else begin
            m_pos++;
         end
      end
   endtask

   function automatic logic [2:0] exp_vec();
      logic hi;
      hi = m_run && ((m_pos < m_r / 2) || (DUTY && (m_r % 2 == 1) && (m_pos == m_r / 2)));
      return {hi, m_run && (m_pos == m_r - 1), m_err};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      model_edge();
      #2;
   endtask

   task automatic sync_start(input int r, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_run && m_pos == 0 && m_r == r) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; ratio = div_ratio_t'(2);
      repeat (3) tick();
      n_checks++;
      if ({clk_out, mod_out, ratio_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_state: got %b want 000", {clk_out, mod_out, ratio_err});
      end
      en = 1'b0; rst_n = 1'b1;
      repeat (2) tick();
      n_checks++;
      if ({clk_out, mod_out, ratio_err} !== 3'b000) begin
         n_fail++; $display("FAIL idle_hold: got %b want 000", {clk_out, mod_out, ratio_err});
      end
      en = 1'b1;
      tick();
      n_checks++;
      if (clk_out !== 1'b1) begin
         n_fail++; $display("FAIL start_latency: clk_out got %b want 1", clk_out);
      end
   endtask

   task automatic test_ratio2();
      bit ok;
      ratio = div_ratio_t'(2);
      sync_start(2, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL r2_sync: got timeout want start"); end
      repeat (2) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL r2_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
      n_checks++;
      if (last_period !== 2 * TCLK) begin
         n_fail++; $display("FAIL r2_period: got %0t want %0t", last_period, 2 * TCLK);
      end
      n_checks++;
      if (last_high !== TCLK) begin
         n_fail++; $display("FAIL r2_high: got %0t want %0t", last_high, TCLK);
      end
   endtask

   task automatic test_ratio3();
      bit ok;
      ratio = div_ratio_t'(3);
      sync_start(3, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL r3_sync: got timeout want start"); end
      repeat (3) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL r3_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
      n_checks++;
      if (last_period !== 3 * TCLK) begin
         n_fail++; $display("FAIL r3_period: got %0t want %0t", last_period, 3 * TCLK);
      end
      n_checks++;
      if (last_high !== R3_HIGH) begin
         n_fail++; $display("FAIL r3_high: got %0t want %0t", last_high, R3_HIGH);
      end
   endtask

   task automatic test_switch();
      bit ok;
      ratio = div_ratio_t'(5);
      sync_start(5, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL sw_sync: got timeout want start"); end
      for (int i = 0; i < 9; i++) begin
         if (i == 2) ratio = div_ratio_t'(4);
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL sw_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
         if (i == 4) begin
            n_checks++;
            if (last_period !== 5 * TCLK) begin
               n_fail++; $display("FAIL sw_old_period: got %0t want %0t", last_period, 5 * TCLK);
            end
            n_checks++;
            if (last_high !== R5_HIGH) begin
               n_fail++; $display("FAIL sw_old_high: got %0t want %0t", last_high, R5_HIGH);
            end
         end
      end
      n_checks++;
      if (last_period !== 4 * TCLK || last_high !== 2 * TCLK) begin
         n_fail++; $display("FAIL sw_new_period: got %0t/%0t want %0t/%0t",
                            last_period, last_high, 4 * TCLK, 2 * TCLK);
      end
   endtask

   task automatic test_ratio_err();
      bit ok;
      ratio = div_ratio_t'(6);
      sync_start(6, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL err_sync: got timeout want start"); end
      ratio = div_ratio_t'(1);
      repeat (6) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL err_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
      n_checks++;
      if (ratio_err !== 1'b1) begin
         n_fail++; $display("FAIL err_set: got %b want 1", ratio_err);
      end
      ratio = div_ratio_t'(7);
      repeat (6) tick();
      n_checks++;
      if (last_period !== 6 * TCLK || ratio_err !== 1'b0) begin
         n_fail++; $display("FAIL err_sub_period: got %0t err=%b want %0t err=0",
                            last_period, ratio_err, 6 * TCLK);
      end
      repeat (7) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL err_r7_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
      n_checks++;
      if (last_period !== 7 * TCLK) begin
         n_fail++; $display("FAIL err_r7_period: got %0t want %0t", last_period, 7 * TCLK);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      ratio = div_ratio_t'(9);
      sync_start(9, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rst_sync: got timeout want start"); end
      ratio = div_ratio_t'(0);
      repeat (12) tick();
      n_checks++;
      if ({clk_out, ratio_err} !== 2'b11) begin
         n_fail++; $display("FAIL rst_pre: got %b want 11", {clk_out, ratio_err});
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({clk_out, mod_out, ratio_err} !== 3'b000) begin
         n_fail++; $display("FAIL rst_async: got %b want 000", {clk_out, mod_out, ratio_err});
      end
      model_edge();
      repeat (2) tick();
      ratio = div_ratio_t'(9);
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (clk_out !== 1'b1) begin
         n_fail++; $display("FAIL rst_restart: clk_out got %b want 1", clk_out);
      end
      repeat (9) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL rst_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
   endtask

   task automatic test_enable_freeze();
      bit ok;
      logic [2:0] hold;
      ratio = div_ratio_t'(6);
      sync_start(6, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL frz_sync: got timeout want start"); end
      repeat (2) tick();
      hold = {clk_out, mod_out, ratio_err};
      en = 1'b0;
      repeat (4) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== hold) begin
            n_fail++; $display("FAIL frz_hold: got %b want %b", {clk_out, mod_out, ratio_err}, hold);
         end
      end
      en = 1'b1;
      repeat (4) begin
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL frz_cycle: got %b want %b", {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
      n_checks++;
      if (last_period !== 10 * TCLK) begin
         n_fail++; $display("FAIL frz_period: got %0t want %0t", last_period, 10 * TCLK);
      end
   endtask

   task automatic test_random();
      bit ok;
      ratio = div_ratio_t'(2 ** W - 1);
      sync_start(2 ** W - 1, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL max_sync: got timeout want start"); end
      repeat (2 ** W - 1) tick();
      n_checks++;
      if (last_period !== (2 ** W - 1) * TCLK) begin
         n_fail++; $display("FAIL max_period: got %0t want %0t", last_period, (2 ** W - 1) * TCLK);
      end
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) ratio = div_ratio_t'($urandom_range(0, 2 ** W - 1));
         en = DUTY ? 1'b1 : ($urandom_range(0, 9) != 0);
         tick(); n_checks++;
         if ({clk_out, mod_out, ratio_err} !== exp_vec()) begin
            n_fail++; $display("FAIL rand_cycle %0d: got %b want %b", i, {clk_out, mod_out, ratio_err}, exp_vec());
         end
      end
      en = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; ratio = '0;
      n_checks = 0; n_fail = 0;
      m_run = 1'b0; m_pos = 0; m_r = 2; m_err = 1'b0;
      test_reset();
      test_ratio2();
      test_ratio3();
      test_switch();
      test_ratio_err();
      test_mid_reset();
      test_enable_freeze();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #(TCLK * 20000);
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
